// File: rtl/bsg_cache_to_dram_ctrl_tx_mc_pkg.sv
// Shared sizing helpers and parameter legality checks for the DMA-to-DRAM write-data path.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package bsg_cache_to_dram_ctrl_tx_mc_pkg;

    // Index width that never collapses to zero bits
    function automatic int lg_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // DRAM beats per DMA word
    function automatic int ratio_f(input int dma_w, input int dram_w);
        return dma_w / dram_w;
    endfunction

    // DRAM beats per DMA burst
    function automatic int beats_per_burst_f(input int dma_burst_len, input int dma_w, input int dram_w);
        return dma_burst_len * ratio_f(dma_w, dram_w);
    endfunction

    // Widths must split evenly into bytes, beats and controller bursts
    function automatic bit params_legal_f(input int dma_w, input int dma_burst_len, input int mask_w,
                                          input int dram_w, input int dram_burst_len);
        int burst_bytes;
        burst_bytes = dma_burst_len * dma_w / 8;
        return (dram_w % 8 == 0) && (dma_w % dram_w == 0)
            && (beats_per_burst_f(dma_burst_len, dma_w, dram_w) % dram_burst_len == 0)
            && (burst_bytes % mask_w == 0);
    endfunction

endpackage

// File: rtl/bsg_expand_bitmask.sv
// Replicates each input bit expand_p times (bit k drives output bits [k*expand_p +: expand_p]).
// Latency: combinational.
// Backpressure: none.
module bsg_expand_bitmask #(
    parameter int in_width_p = 4,
    parameter int expand_p   = 1
) (
    input  logic [in_width_p-1:0]          i,
    output logic [in_width_p*expand_p-1:0] o
);
    for (genvar k = 0; k < in_width_p; k++) begin : g_bit
        assign o[k*expand_p +: expand_p] = {expand_p{i[k]}};
    end
endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO; the head is visible combinationally on data_o.
// Latency: an entry written into an empty FIFO is visible on v_o/data_o the next cycle.
// Backpressure: ready_o drops when full; v_i while full is only legal together with yumi_i (slot recycled).
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int lg_cnt_lp = $clog2(els_p + 1);

    logic [width_p-1:0]   mem [els_p];
    logic [lg_els_lp-1:0] rptr_r, wptr_r;
    logic [lg_cnt_lp-1:0] count_r;
    logic                 deq;

    assign deq     = yumi_i & v_o;
    assign ready_o = (count_r != lg_cnt_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem[rptr_r];

    // Pointers and occupancy; push and pop in one cycle leave the count unchanged
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (v_i)
                wptr_r <= (wptr_r == lg_els_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
            if (deq)
                rptr_r <= (rptr_r == lg_els_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
            count_r <= count_r + {{(lg_cnt_lp-1){1'b0}}, v_i} - {{(lg_cnt_lp-1){1'b0}}, deq};
        end
    end

    // Storage needs no reset; occupancy qualifies it
    always_ff @(posedge clk_i) begin
        if (v_i)
            mem[wptr_r] <= data_i;
    end
endmodule

// File: rtl/bsg_cache_to_dram_ctrl_tx_mc.sv
// Serves queued write bursts in command order: slices DMA words into DRAM beats with inverted byte mask; macro BSG_CACHE_TO_DRAM_CTRL_TX_OUT_REG_EN adds an output register.
// Latency: combinational DMA/queue head to app_wdf_*; one cycle with the output register.
// Backpressure: app_wdf_rdy_i low freezes counters and withholds yumi; wr_ch_ready_o low when the channel queue is full.
module bsg_cache_to_dram_ctrl_tx_mc
    import bsg_cache_to_dram_ctrl_tx_mc_pkg::*;
#(
    parameter int num_dma_p              = 2,
    parameter int dma_data_width_p       = 64,
    parameter int dma_burst_len_p        = 4,
    parameter int dma_mask_width_p       = 4,
    parameter int dram_ctrl_data_width_p = 32,
    parameter int dram_ctrl_burst_len_p  = 4,
    parameter int ch_fifo_els_p          = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     wr_ch_v_i,
    input  logic [lg_f(num_dma_p)-1:0]               wr_ch_i,
    output logic                                     wr_ch_ready_o,
    input  logic [num_dma_p*dma_data_width_p-1:0]    dma_data_i,
    input  logic [num_dma_p*dma_mask_width_p-1:0]    dma_mask_i,
    input  logic [num_dma_p-1:0]                     dma_data_v_i,
    output logic [num_dma_p-1:0]                     dma_data_yumi_o,
    output logic                                     app_wdf_wren_o,
    output logic [dram_ctrl_data_width_p-1:0]        app_wdf_data_o,
    output logic [dram_ctrl_data_width_p/8-1:0]      app_wdf_mask_o,
    output logic                                     app_wdf_end_o,
    input  logic                                     app_wdf_rdy_i
);
    localparam int ratio_lp       = ratio_f(dma_data_width_p, dram_ctrl_data_width_p);
    localparam int beats_lp       = beats_per_burst_f(dma_burst_len_p, dma_data_width_p, dram_ctrl_data_width_p);
    localparam int beat_bytes_lp  = dram_ctrl_data_width_p / 8;
    localparam int burst_bytes_lp = dma_burst_len_p * dma_data_width_p / 8;
    localparam int mask_expand_lp = burst_bytes_lp / dma_mask_width_p;
    localparam int lg_ch_lp       = lg_f(num_dma_p);
    localparam int lg_sub_lp      = lg_f(ratio_lp);
    localparam int lg_word_lp     = lg_f(dma_burst_len_p);
    localparam int lg_beat_lp     = lg_f(dram_ctrl_burst_len_p);
    localparam int lg_slice_lp    = lg_f(beats_lp);

    if (!params_legal_f(dma_data_width_p, dma_burst_len_p, dma_mask_width_p,
                        dram_ctrl_data_width_p, dram_ctrl_burst_len_p)) begin : g_illegal
        $error("bsg_cache_to_dram_ctrl_tx_mc: illegal width/burst parameter combination");
    end

    logic                  q_v, q_enq, take, pop;
    logic [lg_ch_lp-1:0]   ch_r;
    logic [lg_sub_lp-1:0]  sub_r;
    logic [lg_word_lp-1:0] word_r;
    logic [lg_beat_lp-1:0] beat_r;
    logic                  sub_last, word_last, beat_last;

    // A push landing on the pop cycle reuses the freed slot, so a full queue stays full
    assign q_enq = wr_ch_v_i & (wr_ch_ready_o | pop);

    bsg_fifo_1r1w_small #(.width_p(lg_ch_lp), .els_p(ch_fifo_els_p)) ch_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (q_enq),
        .ready_o (wr_ch_ready_o),
        .data_i  (wr_ch_i),
        .v_o     (q_v),
        .data_o  (ch_r),
        .yumi_i  (pop)
    );

    logic [dma_data_width_p-1:0]       words  [num_dma_p];
    logic [dma_mask_width_p-1:0]       masks  [num_dma_p];
    logic [dram_ctrl_data_width_p-1:0] slices [ratio_lp];
    logic [beat_bytes_lp-1:0]          mslices[beats_lp];
    logic [burst_bytes_lp-1:0]         byte_en;
    logic [lg_slice_lp-1:0]            slice_idx;

    for (genvar c = 0; c < num_dma_p; c++) begin : g_ch
        assign words[c] = dma_data_i[c*dma_data_width_p +: dma_data_width_p];
        assign masks[c] = dma_mask_i[c*dma_mask_width_p +: dma_mask_width_p];
    end

    for (genvar s = 0; s < ratio_lp; s++) begin : g_sub
        assign slices[s] = words[ch_r][s*dram_ctrl_data_width_p +: dram_ctrl_data_width_p];
    end

    bsg_expand_bitmask #(.in_width_p(dma_mask_width_p), .expand_p(mask_expand_lp)) mask_exp (
        .i (masks[ch_r]),
        .o (byte_en)
    );

    // Controller mask is active-high "skip this byte", the inverse of the DMA write enables
    for (genvar b = 0; b < beats_lp; b++) begin : g_mslice
        assign mslices[b] = ~byte_en[b*beat_bytes_lp +: beat_bytes_lp];
    end

    assign slice_idx = lg_slice_lp'(word_r * ratio_lp) + lg_slice_lp'(sub_r);
    assign sub_last  = (sub_r  == lg_sub_lp'(ratio_lp - 1));
    assign word_last = (word_r == lg_word_lp'(dma_burst_len_p - 1));
    assign beat_last = (beat_r == lg_beat_lp'(dram_ctrl_burst_len_p - 1));

    logic                              beat_v, beat_end;
    logic [dram_ctrl_data_width_p-1:0] beat_data;
    logic [beat_bytes_lp-1:0]          beat_mask;

    assign beat_v    = q_v & dma_data_v_i[ch_r];
    assign beat_end  = beat_v & beat_last;
    assign beat_data = slices[sub_r];
    assign beat_mask = mslices[slice_idx];
    assign pop       = take & sub_last & word_last;

    // Beat, word and controller-burst counters; burst completion realigns all three
    always_ff @(posedge clk_i) begin
        if (reset_i || pop) begin
            sub_r  <= '0;
            word_r <= '0;
            beat_r <= '0;
        end else if (take) begin
            sub_r  <= sub_last  ? '0 : sub_r + 1'b1;
            beat_r <= beat_last ? '0 : beat_r + 1'b1;
            if (sub_last)
                word_r <= word_last ? '0 : word_r + 1'b1;
        end
    end

    // Only the active channel is acknowledged, once its last slice leaves
    always_comb begin
        dma_data_yumi_o = '0;
        if (take && sub_last)
            dma_data_yumi_o[ch_r] = 1'b1;
    end

`ifdef BSG_CACHE_TO_DRAM_CTRL_TX_OUT_REG_EN
    logic                              out_v_r, out_end_r, load;
    logic [dram_ctrl_data_width_p-1:0] out_data_r;
    logic [beat_bytes_lp-1:0]          out_mask_r;

    assign load = ~out_v_r | app_wdf_rdy_i;
    assign take = beat_v & load;

    // Output stage refills whenever it is empty or its beat is being accepted
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_v_r    <= 1'b0;
            out_end_r  <= 1'b0;
            out_data_r <= '0;
            out_mask_r <= '0;
        end else if (load) begin
            out_v_r    <= beat_v;
            out_end_r  <= beat_end;
            out_data_r <= beat_data;
            out_mask_r <= beat_mask;
        end
    end

    assign app_wdf_wren_o = out_v_r;
    assign app_wdf_end_o  = out_end_r;
    assign app_wdf_data_o = out_data_r;
    assign app_wdf_mask_o = out_mask_r;
`else
    assign take           = beat_v & app_wdf_rdy_i;
    assign app_wdf_wren_o = beat_v;
    assign app_wdf_end_o  = beat_end;
    assign app_wdf_data_o = beat_data;
    assign app_wdf_mask_o = beat_mask;
`endif

    wr_ch_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(wr_ch_v_i && !wr_ch_ready_o && !pop));

endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_tx_mc.sv
// Directed table-driven bench for bsg_cache_to_dram_ctrl_tx_mc in its default configuration.
// Latency: expects combinational beats, active channel one cycle after push.
// Backpressure: exercises rdy stalls, invalid DMA words and a full channel queue.
module tb_bsg_cache_to_dram_ctrl_tx_mc;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         wr_ch_v_i;
    logic [0:0]   wr_ch_i;
    logic         wr_ch_ready_o;
    logic [127:0] dma_data_i;
    logic [7:0]   dma_mask_i;
    logic [1:0]   dma_data_v_i;
    logic [1:0]   dma_data_yumi_o;
    logic         app_wdf_wren_o;
    logic [31:0]  app_wdf_data_o;
    logic [3:0]   app_wdf_mask_o;
    logic         app_wdf_end_o;
    logic         app_wdf_rdy_i;

    always #5 clk = ~clk;

    bsg_cache_to_dram_ctrl_tx_mc dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .wr_ch_v_i       (wr_ch_v_i),
        .wr_ch_i         (wr_ch_i),
        .wr_ch_ready_o   (wr_ch_ready_o),
        .dma_data_i      (dma_data_i),
        .dma_mask_i      (dma_mask_i),
        .dma_data_v_i    (dma_data_v_i),
        .dma_data_yumi_o (dma_data_yumi_o),
        .app_wdf_wren_o  (app_wdf_wren_o),
        .app_wdf_data_o  (app_wdf_data_o),
        .app_wdf_mask_o  (app_wdf_mask_o),
        .app_wdf_end_o   (app_wdf_end_o),
        .app_wdf_rdy_i   (app_wdf_rdy_i)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic        pch;
        logic        rdy;
        logic [1:0]  dv;
        logic [7:0]  mask;
        logic        e_wren;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        logic        e_end;
        logic [1:0]  e_yumi;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   src_idx[2];

    // Word idx of channel c: low half carries beat 2*idx, high half beat 2*idx+1
    function automatic logic [63:0] src_word(input int c, input int idx);
        logic [31:0] base;
        base = 32'hA000_0000 | (32'(c) << 8);
        return {base | 32'(2*idx + 1), base | 32'(2*idx)};
    endfunction

    function automatic void add_idle(input logic pv, input logic pch, input logic [1:0] dv, input logic [7:0] mask);
        vec_t v;
        v.rst = 1'b0; v.pv = pv; v.pch = pch; v.rdy = 1'b1; v.dv = dv; v.mask = mask;
        v.e_wren = 1'b0; v.e_data = '0; v.e_mask = '0; v.e_end = 1'b0; v.e_yumi = 2'b00;
        vecs.push_back(v);
    endfunction

    // Beat n (0..7) of a burst on channel ch
    function automatic void add_beat(input logic rst, input logic pv, input logic pch, input logic rdy,
                                     input logic [1:0] dv, input logic [7:0] mask, input int ch, input int n);
        vec_t v;
        logic [3:0] mb;
        mb = (ch == 1) ? mask[7:4] : mask[3:0];
        v.rst = rst; v.pv = pv; v.pch = pch; v.rdy = rdy; v.dv = dv; v.mask = mask;
        v.e_wren = 1'b1;
        v.e_data = 32'hA000_0000 | (32'(ch) << 8) | 32'(n);
        v.e_mask = mb[n/2] ? 4'h0 : 4'hF;
        v.e_end  = (n % 4 == 3);
        v.e_yumi = (rdy && (n % 2 == 1)) ? ((ch == 1) ? 2'b10 : 2'b01) : 2'b00;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        dma_data_i = {src_word(1, src_idx[1]), src_word(0, src_idx[0])};
    endtask

    // Advance one clock; the DMA source model steps its word on yumi and restarts on reset
    task automatic tick();
        logic [1:0] y;
        logic       r;
        y = dma_data_yumi_o;
        r = reset_i;
        @(posedge clk);
        #1;
        if (r) begin
            src_idx[0] = 0;
            src_idx[1] = 0;
        end else begin
            for (int c = 0; c < 2; c++)
                if (y[c]) src_idx[c] = (src_idx[c] + 1) % 4;
        end
    endtask

    initial begin
        int beats;
        src_idx[0] = 0; src_idx[1] = 0;
        reset_i = 1'b1; wr_ch_v_i = 1'b0; wr_ch_i = '0; dma_mask_i = '0;
        dma_data_v_i = '0; app_wdf_rdy_i = 1'b0;
        drive();

        // Single channel, full mask
        add_idle(1'b1, 1'b0, 2'b01, 8'h0F);
        for (int n = 0; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'h0F, 0, n);
        // Partial mask 0101
        add_idle(1'b1, 1'b0, 2'b01, 8'h05);
        for (int n = 0; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'h05, 0, n);
        // ch1 then ch0, both valid, no bubble between bursts
        add_idle(1'b1, 1'b1, 2'b11, 8'hFF);
        add_beat(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 8'hFF, 1, 0);
        for (int n = 1; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'hFF, 1, n);
        for (int n = 0; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'hFF, 0, n);
        // rdy 1,0,0,1 stalls, then invalid word and other-channel-only valid
        add_idle(1'b1, 1'b0, 2'b01, 8'hFF);
        add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, 0);
        add_beat(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'hFF, 0, 1);
        add_beat(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'hFF, 0, 1);
        add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, 1);
        add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, 2);
        add_idle(1'b0, 1'b0, 2'b00, 8'hFF);
        add_idle(1'b0, 1'b0, 2'b10, 8'hFF);
        for (int n = 3; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, n);
        // Reset after beat 3, then a fresh burst from zero
        add_idle(1'b1, 1'b0, 2'b01, 8'hFF);
        for (int n = 0; n < 4; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, n);
        add_beat(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, 4);
        add_idle(1'b0, 1'b0, 2'b01, 8'hFF);
        add_idle(1'b1, 1'b0, 2'b01, 8'hFF);
        for (int n = 0; n < 8; n++) add_beat(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'hFF, 0, n);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("reset_wren",  32'(app_wdf_wren_o),  32'd0);
        chk("reset_end",   32'(app_wdf_end_o),   32'd0);
        chk("reset_yumi",  32'(dma_data_yumi_o), 32'd0);
        chk("reset_ready", 32'(wr_ch_ready_o),   32'd1);
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            reset_i = vecs[i].rst; wr_ch_v_i = vecs[i].pv; wr_ch_i = vecs[i].pch;
            app_wdf_rdy_i = vecs[i].rdy; dma_data_v_i = vecs[i].dv; dma_mask_i = vecs[i].mask;
            drive();
            #1;
            chk($sformatf("row%0d_wren", i),  32'(app_wdf_wren_o),  32'(vecs[i].e_wren));
            chk($sformatf("row%0d_end", i),   32'(app_wdf_end_o),   32'(vecs[i].e_end));
            chk($sformatf("row%0d_yumi", i),  32'(dma_data_yumi_o), 32'(vecs[i].e_yumi));
            chk($sformatf("row%0d_ready", i), 32'(wr_ch_ready_o),   32'd1);
            if (vecs[i].e_wren) begin
                chk($sformatf("row%0d_data", i), app_wdf_data_o,      vecs[i].e_data);
                chk($sformatf("row%0d_mask", i), 32'(app_wdf_mask_o), 32'(vecs[i].e_mask));
            end
            tick();
        end

        // Fill the queue while the DMA side is idle
        reset_i = 1'b0; app_wdf_rdy_i = 1'b1; dma_data_v_i = 2'b00; dma_mask_i = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            wr_ch_v_i = 1'b1; wr_ch_i = 1'b0; drive(); #1;
            chk($sformatf("fill%0d_ready", k), 32'(wr_ch_ready_o), 32'd1);
            tick();
        end
        wr_ch_v_i = 1'b0; drive(); #1;
        chk("full_ready", 32'(wr_ch_ready_o), 32'd0);
        tick();

        // Drain one burst, pushing again on its completing beat
        dma_data_v_i = 2'b01;
        for (int n = 0; n < 8; n++) begin
            wr_ch_v_i = (n == 7); drive(); #1;
            chk($sformatf("full_beat%0d_data", n), app_wdf_data_o, 32'hA000_0000 | 32'(n));
            chk($sformatf("full_beat%0d_ready", n), 32'(wr_ch_ready_o), 32'd0);
            tick();
        end
        wr_ch_v_i = 1'b0; dma_data_v_i = 2'b00; drive(); #1;
        chk("pushpop_ready", 32'(wr_ch_ready_o), 32'd0);
        tick();

        // Four bursts must remain queued
        dma_data_v_i = 2'b01;
        beats = 0;
        for (int k = 0; k < 60; k++) begin
            drive(); #1;
            if (app_wdf_wren_o) beats++;
            tick();
        end
        chk("drain_beats", 32'(beats), 32'd32);
        chk("drain_ready", 32'(wr_ch_ready_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
